bidir_line_ctrl: RTL and testbench
==================================

BIDIR_LINE_CTRL -- requirements
Module: bidir_line_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2: bus turnaround cycles with no driver, legal range 1..15.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum bytes per grant in either direction, legal range 1..255.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is synchronous to clk_i.
REQ-005 SHALL have port tx_valid_i  input  1  transmit requester has a byte on tx_data_i.
REQ-006 SHALL have port tx_data_i  input  8  byte to drive onto the line.
REQ-007 SHALL have port tx_ready_o  output  1  controller accepts tx_data_i this cycle.
REQ-008 SHALL have port rx_en_i  input  1  receive requester wants the line sampled.
REQ-009 SHALL have port rx_valid_o  output  1  rx_data_o holds a new sample (one-cycle pulse per sample).
REQ-010 SHALL have port rx_data_o  output  8  sampled line byte.
REQ-011 SHALL have port line_oe_o  output  1  tri-state enable for the shared 8-bit line (1 = drive).
REQ-012 SHALL have port line_dout_o  output  8  byte driven when line_oe_o=1.
REQ-013 SHALL have port line_din_i  input  8  line value read back from the pad.
REQ-014 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, TURN_TX, DRIVE, TURN_REL, RX.
REQ-016 IDLE: if tx_valid_i and rx_en_i are both high, SHALL grant the direction not granted last (round-robin); a single requester SHALL be granted directly. A TX grant SHALL go to TURN_TX and an RX grant SHALL go to RX.
REQ-017 TURN_TX: SHALL hold line_oe_o=0 for exactly TURN_CYCLES cycles, then SHALL enter DRIVE.
REQ-018 DRIVE: tx_ready_o SHALL be 1 combinationally while burst count < MAX_BURST.
REQ-019 DRIVE: on tx_valid_i&tx_ready_o, line_dout_o SHALL register tx_data_i and line_oe_o SHALL be 1 in the next cycle, so each accepted byte is driven for exactly one cycle.
REQ-020 DRIVE: the first clock edge without an accepted byte, or the edge after the MAX_BURST-th byte is accepted, SHALL clear line_oe_o and SHALL enter TURN_REL.
REQ-021 TURN_REL: SHALL hold line_oe_o=0 for TURN_CYCLES cycles, then SHALL return to IDLE with last grant set to TX.
REQ-022 RX: line_oe_o SHALL be 0. On each cycle with rx_en_i=1, rx_data_o SHALL register line_din_i and rx_valid_o SHALL pulse 1 in the next cycle.
REQ-023 RX: rx_en_i=0 SHALL return the block to IDLE. After MAX_BURST samples, if tx_valid_i=1 the block SHALL return to IDLE (last grant = RX); otherwise it SHALL keep sampling and reset the sample count.
REQ-024 line_oe_o SHALL be 1 only in the cycle after a DRIVE acceptance, and SHALL never be 1 within TURN_CYCLES cycles after RX is exited.
REQ-025 line_dout_o SHALL hold its last value when line_oe_o=0.
REQ-026 The burst and turnaround counters SHALL be 8-bit and 4-bit and SHALL clear on every state entry. No counter SHALL wrap.
REQ-027 tx_ready_o SHALL be 0 in every state except DRIVE. rx_valid_o SHALL be 0 in every state except the cycle after an RX sample.
REQ-028 Latency: tx_valid_i rising in IDLE SHALL produce the first line_oe_o=1 exactly TURN_CYCLES+2 cycles later.
REQ-029 Changes on tx_data_i while tx_ready_o=0 SHALL be ignored.

Reset
REQ-030 While rst_i=0: state SHALL be IDLE, last grant SHALL be RX (TX wins the first tie), all counters SHALL be 0, and line_oe_o, line_dout_o, tx_ready_o, rx_valid_o, rx_data_o and busy_o SHALL all be 0.
REQ-031 Reset asserted mid-DRIVE SHALL drop line_oe_o to 0 asynchronously, with no further byte accepted.

Verification
REQ-032 Single TX: TURN_CYCLES=2, tx_valid_i=1 with data 8'hC3 for one accept -> line_oe_o=1 with line_dout_o=C3 for one cycle 4 cycles after the request, then 2 idle turnaround cycles, then IDLE.
REQ-033 Burst limit: MAX_BURST=4, tx_valid_i held with bytes AA,55,3C,E7,0F -> exactly 4 bytes are driven; 0F waits, and after TURN_REL and a fresh TURN_TX it is driven.
REQ-034 Tie: reset, then tx_valid_i and rx_en_i both set in IDLE -> TX is granted first; after TURN_REL, RX is granted and samples line_din_i=8'h5A with rx_valid_o pulses.
REQ-035 RX yield: rx_en_i held with tx_valid_i=1 -> after 4 samples the block returns to IDLE and then TURN_TX; line_oe_o stays 0 for at least TURN_CYCLES cycles after RX exit.
REQ-036 Reset mid-burst: rst_i=0 while line_oe_o=1 -> all outputs go to 0 before the next clock edge; after release the block is in IDLE.
REQ-037 An assertion SHALL hold throughout every test: line_oe_o=1 implies state DRIVE.

Source files
------------

// File: rtl/bidir_line_ctrl.sv
// rtl/bidir_line_ctrl.sv - half-duplex shared-line arbiter with turnaround and burst limits
module bidir_line_ctrl #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    input  logic       rx_en_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       line_oe_o,
    output logic [7:0] line_dout_o,
    input  logic [7:0] line_din_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        TURN_TX,
        DRIVE,
        TURN_REL,
        RX
    } state_t;

    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state;
    logic [7:0] burst_cnt;
    logic [3:0] turn_cnt;
    logic       last_tx;
    logic       accept;

    // Ready only while driving and the burst budget is not yet spent.
    assign tx_ready_o = (state == DRIVE) && (burst_cnt < BURST_MAX);
    assign busy_o     = (state != IDLE);
    assign accept     = tx_valid_i && tx_ready_o;

    // Main controller: arbitration, turnaround timing, byte drive and line sampling.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            burst_cnt   <= 8'd0;
            turn_cnt    <= 4'd0;
            last_tx     <= 1'b0;
            line_oe_o   <= 1'b0;
            line_dout_o <= 8'd0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= 8'd0;
        end else begin
            rx_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    burst_cnt <= 8'd0;
                    turn_cnt  <= 4'd0;
                    // On a tie, the direction not served last time wins.
                    if (tx_valid_i && (!rx_en_i || !last_tx)) begin
                        state <= TURN_TX;
                    end else if (rx_en_i) begin
                        state <= RX;
                    end
                end
                TURN_TX: begin
                    if (turn_cnt == TURN_LAST) begin
                        state     <= DRIVE;
                        turn_cnt  <= 4'd0;
                        burst_cnt <= 8'd0;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                DRIVE: begin
                    if (accept) begin
                        line_dout_o <= tx_data_i;
                        line_oe_o   <= 1'b1;
                        burst_cnt   <= burst_cnt + 8'd1;
                    end else begin
                        // Any edge without a new byte ends the grant, including
                        // the one after the burst budget is exhausted.
                        line_oe_o <= 1'b0;
                        state     <= TURN_REL;
                        turn_cnt  <= 4'd0;
                        burst_cnt <= 8'd0;
                    end
                end
                TURN_REL: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= IDLE;
                        last_tx  <= 1'b1;
                        turn_cnt <= 4'd0;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                RX: begin
                    if (!rx_en_i) begin
                        state     <= IDLE;
                        last_tx   <= 1'b0;
                        burst_cnt <= 8'd0;
                    end else begin
                        rx_data_o  <= line_din_i;
                        rx_valid_o <= 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            // A full receive burst yields only if the transmitter is waiting.
                            burst_cnt <= 8'd0;
                            if (tx_valid_i) begin
                                state   <= IDLE;
                                last_tx <= 1'b0;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The pad may only be driven while the transmitter owns the line.
    assert property (@(posedge clk_i) disable iff (!rst_i) line_oe_o |-> (state == DRIVE));

endmodule

// File: tb/tb_bidir_line_ctrl.sv
// tb/tb_bidir_line_ctrl.sv - directed self-checking bench for bidir_line_ctrl
module tb_bidir_line_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       rx_en_i;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       line_oe_o;
    logic [7:0] line_dout_o;
    logic [7:0] line_din_i;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] oe_log, busy_log, rdy_log, rxv_log;
    logic [7:0]  dout_log [32];
    logic [7:0]  rxd_log  [32];
    logic [7:0]  tx_bytes [8];

    bidir_line_ctrl #(.TURN_CYCLES(2), .MAX_BURST(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_ready_o (tx_ready_o),
        .rx_en_i    (rx_en_i),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .line_oe_o  (line_oe_o),
        .line_dout_o(line_dout_o),
        .line_din_i (line_din_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        oe_log   = '0;
        busy_log = '0;
        rdy_log  = '0;
        rxv_log  = '0;
        for (int i = 0; i < 32; i++) begin
            dout_log[i] = 8'd0;
            rxd_log[i]  = 8'd0;
        end
    endtask

    // One rising edge, then record every output 1 ns later under index k.
    task automatic step(input int k);
        @(posedge clk_i);
        #1;
        oe_log[k]   = line_oe_o;
        busy_log[k] = busy_o;
        rdy_log[k]  = tx_ready_o;
        rxv_log[k]  = rx_valid_o;
        dout_log[k] = line_dout_o;
        rxd_log[k]  = rx_data_o;
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'd0;
        rx_en_i    = 1'b0;
        line_din_i = 8'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Present tx_bytes[0..nbytes-1] back to back, advancing on each accept.
    task automatic run_tx(input int nbytes, input int ncyc);
        int  idx;
        logic acc;
        idx = 0;
        tx_valid_i = 1'b1;
        tx_data_i  = tx_bytes[0];
        for (int k = 1; k <= ncyc; k++) begin
            acc = tx_valid_i && tx_ready_o;
            step(k);
            if (acc) begin
                idx++;
                if (idx < nbytes) begin
                    tx_data_i = tx_bytes[idx];
                end else begin
                    tx_valid_i = 1'b0;
                    tx_data_i  = 8'h99;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        rst_i      = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        rx_en_i    = 1'b0;
        line_din_i = 8'h00;
        #12;
        check("rst_oe",    32'(line_oe_o),   32'h0);
        check("rst_dout",  32'(line_dout_o), 32'h0);
        check("rst_ready", 32'(tx_ready_o),  32'h0);
        check("rst_rxv",   32'(rx_valid_o),  32'h0);
        check("rst_rxd",   32'(rx_data_o),   32'h0);
        check("rst_busy",  32'(busy_o),      32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single TX byte: driven 4 cycles after the request, two turnaround cycles, idle
        clear_logs();
        tx_bytes[0] = 8'hC3;
        run_tx(1, 8);
        check("single_oe",    oe_log,   32'h0000_0010);
        check("single_busy",  busy_log, 32'h0000_007E);
        check("single_ready", rdy_log,  32'h0000_0018);
        check("single_dout4", 32'(dout_log[4]), 32'hC3);
        check("single_hold5", 32'(dout_log[5]), 32'hC3);

        // Burst limit: four bytes, then 0F waits for a fresh grant
        clear_logs();
        tx_bytes[0] = 8'hAA;
        tx_bytes[1] = 8'h55;
        tx_bytes[2] = 8'h3C;
        tx_bytes[3] = 8'hE7;
        tx_bytes[4] = 8'h0F;
        run_tx(5, 17);
        check("burst_oe",    oe_log,   32'h0000_40F0);
        check("burst_busy",  busy_log, 32'h0001_FBFE);
        check("burst_ready", rdy_log,  32'h0000_6078);
        check("burst_d4",  32'(dout_log[4]),  32'hAA);
        check("burst_d5",  32'(dout_log[5]),  32'h55);
        check("burst_d6",  32'(dout_log[6]),  32'h3C);
        check("burst_d7",  32'(dout_log[7]),  32'hE7);
        check("burst_d8",  32'(dout_log[8]),  32'hE7);
        check("burst_d10", 32'(dout_log[10]), 32'hE7);
        check("burst_d14", 32'(dout_log[14]), 32'h0F);
        check("burst_d15", 32'(dout_log[15]), 32'h0F);

        // Tie after reset: TX first, then RX, then TX again (round robin)
        do_reset();
        clear_logs();
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h11;
        rx_en_i    = 1'b1;
        line_din_i = 8'h5A;
        for (int k = 1; k <= 20; k++) begin
            step(k);
            if (k == 4) begin
                tx_valid_i = 1'b0;
                tx_data_i  = 8'hEE;
            end
            if (k == 5) begin
                tx_valid_i = 1'b1;
                tx_data_i  = 8'h22;
            end
            if (k == 16) tx_valid_i = 1'b0;
        end
        check("tie_oe",    oe_log,   32'h0001_0010);
        check("tie_busy",  busy_log, 32'h0017_EF7E);
        check("tie_ready", rdy_log,  32'h0001_8018);
        check("tie_rxv",   rxv_log,  32'h0000_1E00);
        check("tie_rxd9",  32'(rxd_log[9]),   32'h5A);
        check("tie_rxd12", 32'(rxd_log[12]),  32'h5A);
        check("tie_d4",    32'(dout_log[4]),  32'h11);
        check("tie_d16",   32'(dout_log[16]), 32'h22);

        // RX yield: receiver keeps the line until a full burst with TX waiting
        do_reset();
        clear_logs();
        rx_en_i    = 1'b1;
        line_din_i = 8'h40;
        for (int k = 1; k <= 20; k++) begin
            step(k);
            line_din_i = 8'(8'h40 + k);
            if (k == 6) begin
                tx_valid_i = 1'b1;
                tx_data_i  = 8'h77;
            end
            if (k == 13) tx_valid_i = 1'b0;
            if (k == 18) rx_en_i = 1'b0;
        end
        check("rxy_oe",    oe_log,   32'h0000_2000);
        check("rxy_busy",  busy_log, 32'h0006_FDFE);
        check("rxy_ready", rdy_log,  32'h0000_3000);
        check("rxy_rxv",   rxv_log,  32'h0004_03FC);
        check("rxy_rxd2",  32'(rxd_log[2]),   32'h41);
        check("rxy_rxd5",  32'(rxd_log[5]),   32'h44);
        check("rxy_rxd9",  32'(rxd_log[9]),   32'h48);
        check("rxy_rxd10", 32'(rxd_log[10]),  32'h48);
        check("rxy_rxd18", 32'(rxd_log[18]),  32'h51);
        check("rxy_rxd19", 32'(rxd_log[19]),  32'h51);
        check("rxy_d13",   32'(dout_log[13]), 32'h77);

        // Reset asserted while a byte is on the line
        clear_logs();
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hAB;
        for (int k = 1; k <= 4; k++) step(k);
        check("mid_oe_pre",   32'(line_oe_o),   32'h1);
        check("mid_dout_pre", 32'(line_dout_o), 32'hAB);
        #1;
        rst_i = 1'b0;
        #1;
        check("mid_oe",    32'(line_oe_o),   32'h0);
        check("mid_dout",  32'(line_dout_o), 32'h0);
        check("mid_ready", 32'(tx_ready_o),  32'h0);
        check("mid_busy",  32'(busy_o),      32'h0);
        check("mid_rxv",   32'(rx_valid_o),  32'h0);
        check("mid_rxd",   32'(rx_data_o),   32'h0);
        tx_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        step(1);
        check("post_busy", 32'(busy_o),    32'h0);
        check("post_oe",   32'(line_oe_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
